// File: rtl/mux_scan_ctrl_if.sv
// Bundle of scan-controller signals between the controller, the 4:1 mux and the consumer.
// The master side is the controller; the slave side is the mux/consumer environment.
interface mux_scan_ctrl_if;
  logic       start;
  logic [3:0] mask;
  logic       y;
  logic [1:0] s;
  logic [3:0] data;
  logic       valid;
  logic       ready;
  logic       busy;

  modport master (
    input  start, mask, y, ready,
    output s, data, valid, busy
  );

  modport slave (
    output start, mask, y, ready,
    input  s, data, valid, busy
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Steps a 4:1 mux through its enabled channels, waits DWELL cycles on each,
// samples y into a 4-bit word and presents the word on a valid/ready handshake.
module mux_scan_ctrl #(
  parameter int DWELL = 2
) (
  input  logic           clk,
  input  logic           rst,
  mux_scan_ctrl_if.master bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;
  localparam logic [3:0] LP_LAST   = 4'(DWELL - 1);

  logic [1:0] r_state;
  logic [1:0] r_idx;
  logic [3:0] r_cnt;
  logic [3:0] r_mask;
  logic [3:0] r_shadow;
  logic [3:0] r_data;
  logic       r_valid;

  logic [1:0] w_firstIdx;
  logic [1:0] w_nextIdx;
  logic       w_hasNext;
  logic [3:0] w_captured;

  // Descending scans leave the lowest qualifying bit as the final assignment.
  always_comb begin
    w_firstIdx = 2'd0;
    w_nextIdx  = r_idx;
    w_hasNext  = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (bus.mask[k]) begin
        w_firstIdx = 2'(k);
      end
      if (r_mask[k] && (k > int'(r_idx))) begin
        w_hasNext = 1'b1;
        w_nextIdx = 2'(k);
      end
    end
  end

  assign w_captured = r_shadow | (4'(bus.y) << r_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_idx    <= 2'd0;
      r_cnt    <= 4'd0;
      r_mask   <= 4'd0;
      r_shadow <= 4'd0;
      r_data   <= 4'd0;
      r_valid  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_mask   <= bus.mask;
            r_shadow <= 4'd0;
            if (bus.mask != 4'd0) begin
              r_idx   <= w_firstIdx;
              r_cnt   <= 4'd0;
              r_state <= ST_SETTLE;
            end else begin
              r_data  <= 4'd0;
              r_valid <= 1'b1;
              r_state <= ST_HOLD;
            end
          end
        end
        ST_SETTLE: begin
          if (r_cnt == LP_LAST) begin
            r_shadow <= w_captured;
            if (w_hasNext) begin
              r_idx <= w_nextIdx;
              r_cnt <= 4'd0;
            end else begin
              r_data  <= w_captured;
              r_valid <= 1'b1;
              r_state <= ST_HOLD;
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ST_HOLD: begin
          if (bus.ready) begin
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // The mux is parked on channel 0 whenever no channel is being settled.
  assign bus.s     = (r_state == ST_SETTLE) ? r_idx : 2'b00;
  assign bus.data  = r_data;
  assign bus.valid = r_valid;
  assign bus.busy  = (r_state != ST_IDLE);

endmodule
